clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Hardware timekeeping and time-set controller for the six-digit 7-segment clock display. It debounces the three board push-buttons (select, mode, increment) and runs a 1 Hz BCD hh:mm:ss counter. A run/set state machine lets the user adjust hours, minutes and seconds. It drives the six digit outputs and the status LEDs directly, so the display keeps running independently of the soft CPU.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- `CLK_HZ`, default 50_000_000: clock cycles per second tick. Must be a multiple of 4.
- `DEBOUNCE_CYCLES`, default 500_000: cycles a synchronized button level must stay stable before it is accepted.
- `clk_clk`  in  1  system clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `btsel_n`, `btmode_n`, `btinc_n`  in  1 each  raw push-buttons, asynchronous, active-low (0 = pressed).
- `seg7s0`, `seg7s1`, `seg7m0`, `seg7m1`, `seg7h0`, `seg7h1`  out  7 each  active-low segments, bit0 = a … bit6 = g. Suffix 0 = units digit, 1 = tens digit.
- `leds`  out  8  status: [3:0] one-hot state (RUN, SET_H, SET_M, SET_S); [4] heartbeat; [7:5] = 0.

## Operation
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on the debounced pressed edge. Releases generate no event.
- Time registers: BCD pairs hh (00–23), mm (00–59), ss (00–59). Non-BCD values are unreachable.
- State machine:
  - RUN: the prescaler counts 0..`CLK_HZ`-1 and emits a tick at `CLK_HZ`-1.
    - The tick increments ss; 59→00 carries into mm; 59→00 carries into hh; 23→00.
    - 23:59:59 rolls to 00:00:00.
    - Each tick toggles `leds[4]`.
  - mode press in RUN → SET_H. The prescaler is cleared and held at 0 in all SET states.
  - sel press: SET_H → SET_M → SET_S → SET_H.
  - inc press: adds 1 to the selected field only, wrapping hh 23→00 and mm/ss 59→00, with no carry. ss = 59 becomes 00, mm unchanged.
  - mode press in any SET state → RUN. The prescaler restarts from 0, so the first tick comes `CLK_HZ` cycles later.
- Simultaneous press events: mode > sel > inc. Lower-priority events in the same cycle are discarded.
- A tick and an inc never coincide, because inc is ignored in RUN and the tick is suppressed in SET.
- Reset values:
  - time 00:00:00; state RUN; prescaler 0; `leds[4]` = 0.
  - debounced levels = released; synchronizers = released (1).
  - every `seg7*` = 7'b1000000 ("0"); `leds` = 8'h01.
- A reset during a SET state or mid-debounce returns everything to the reset values within the same cycle edge.

## Timing
- A press event pulse occurs `DEBOUNCE_CYCLES`+3 cycles after the pin edge. That is 2 synchronizer stages, then the stability count, then 1 edge-detect stage.
- The state or time register updates on the edge following the pulse.
- Segment outputs are registered: one cycle after the time or state change.
- The tick updates ss one cycle after the prescaler reaches `CLK_HZ`-1. The segments follow one cycle later.
- `leds[3:0]` is registered with the state, so it has the same latency as the state update.

## Configuration
- `CLOCK_SET_CTRL_BLINK_EN` defined:
  - In SET states, both digits of the selected field blink at 2 Hz: shown for `CLK_HZ`/4 cycles, then blanked (7'h7F) for `CLK_HZ`/4 cycles.
  - The blink phase resets to "shown" on entry to any SET state and on every inc press.
  - In RUN, nothing blinks.
- Macro undefined: no blink counter is built; all digits are always shown.

## Structure
- Package `clock_set_ctrl_pkg`:
  - state enum {RUN, SET_H, SET_M, SET_S}.
  - BCD limit constants 8'h23 and 8'h59.
  - segment constants: digit patterns 0–9 and the blank pattern.
  - pure function `bcd_to_seg7`.
- Sub-module `button_debounce`, parameterized by `DEBOUNCE_CYCLES` and instantiated three times. It contains the synchronizer, stability counter, debounced level and press pulse.
- The remaining FSM, counters and segment registers live in the top module.

## Test plan
All scenarios use `CLK_HZ`=20 and `DEBOUNCE_CYCLES`=4.
- Reset: assert `reset_reset` for 2 cycles → all `seg7*` = 7'b1000000, `leds` = 8'h01; after 20 cycles ss = 01, after 60 cycles ss = 03, `leds[4]` toggling.
- Rollover: run the clock to 23:59:59 (via set mode) and wait one tick → 00:00:00, with all six digits updating in the same cycle.
- Bounce: toggle `btmode_n` every 2 cycles for 12 cycles, then hold it low → exactly one mode event, `leds` = 8'h02 at pin-settle +8 cycles.
- Set flow: mode, sel, then inc ×61 → mm = 01 (wraps past 59), hh and ss unchanged; mode → `leds` = 8'h01, first tick 20 cycles later.
- Priority: mode and sel pulses arrive in the same cycle while in SET_M → state RUN, field selection not advanced; inc alone in RUN → time unchanged.
- Blink (macro defined): enter SET_H → `seg7h*` show digits for 5 cycles, then 7'h7F for 5 cycles; an inc press restarts the shown phase.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types, BCD limits and 7-segment helpers
// for the clock_set_ctrl display controller.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // active-low, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] bcd_inc_wrap(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [7:0] r;
    if (v == max)
      r = 8'h00;
    else if (v[3:0] == 4'h9)
      r = {v[7:4] + 4'h1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  function automatic logic [3:0] state_onehot(
    input state_t s
  );
    logic [3:0] r;
    case (s)
      RUN:     r = 4'b0001;
      SET_H:   r = 4'b0010;
      SET_M:   r = 4'b0100;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer,
// stability counter and press-edge pulse.
module button_debounce
  import clock_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // sync, accept a level after a full stable run, flag press edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// 1 Hz BCD hh:mm:ss clock with run/set FSM and 7-seg drive.
// Optional blink of the edited field: CLOCK_SET_CTRL_BLINK_EN.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       btsel_n,
  input  logic       btmode_n,
  input  logic       btinc_n,
  output logic [6:0] seg7s0,
  output logic [6:0] seg7s1,
  output logic [6:0] seg7m0,
  output logic [6:0] seg7m1,
  output logic [6:0] seg7h0,
  output logic [6:0] seg7h1,
  output logic [7:0] leds
);

  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic mode_p, sel_p, inc_p;
  logic ev_mode, ev_sel, ev_inc, tick;

  state_t        state_q, state_d;
  logic [7:0]    hh_q, hh_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          hb_q, hb_d;
  logic          blank_h, blank_m, blank_s;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .btn_n(btmode_n),
    .press(mode_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sel (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .btn_n(btsel_n),
    .press(sel_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .btn_n(btinc_n),
    .press(inc_p)
  );

  assign ev_mode = mode_p;
  assign ev_sel  = sel_p & ~mode_p;
  assign ev_inc  = inc_p & ~mode_p & ~sel_p;
  assign tick    = (state_q == RUN) &&
                   (presc_q == PRESC_MAX);

  // state, time, prescaler and heartbeat registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= RUN;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      presc_q <= '0;
      hb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      presc_q <= presc_d;
      hb_q    <= hb_d;
    end
  end

  // run/set transitions, ticking and field edits
  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    presc_d = presc_q;
    hb_d    = hb_q;
    unique case (state_q)
      RUN: begin
        if (ev_mode) begin
          state_d = SET_H;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          hb_d    = ~hb_q;
          ss_d    = bcd_inc_wrap(ss_q, MS_MAX);
          if (ss_q == MS_MAX) begin
            mm_d = bcd_inc_wrap(mm_q, MS_MAX);
            if (mm_q == MS_MAX)
              hh_d = bcd_inc_wrap(hh_q, HH_MAX);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      SET_H, SET_M, SET_S: begin
        presc_d = '0;
        unique case (1'b1)
          ev_mode: state_d = RUN;
          ev_sel: begin
            if (state_q == SET_H)
              state_d = SET_M;
            else if (state_q == SET_M)
              state_d = SET_S;
            else
              state_d = SET_H;
          end
          ev_inc: begin
            if (state_q == SET_H)
              hh_d = bcd_inc_wrap(hh_q, HH_MAX);
            else if (state_q == SET_M)
              mm_d = bcd_inc_wrap(mm_q, MS_MAX);
            else
              ss_d = bcd_inc_wrap(ss_q, MS_MAX);
          end
          default: ;
        endcase
      end
    endcase
  end

`ifdef CLOCK_SET_CTRL_BLINK_EN
  localparam int HALF    = CLK_HZ / 2;
  localparam int QUARTER = CLK_HZ / 4;
  localparam int BW      = $clog2(HALF);

  logic [BW-1:0] blink_q, blink_d;
  logic          blink_clr, blank;

  // blink phase restarts on SET entry and on each edit
  always_comb begin
    blink_clr = (state_d != RUN) &&
                ((state_d != state_q) || ev_inc);
    blink_d   = blink_q + BW'(1);
    if (blink_clr || state_d == RUN)
      blink_d = '0;
    else if (blink_q == BW'(HALF - 1))
      blink_d = '0;
    blank = (state_q != RUN) &&
            (blink_q >= BW'(QUARTER));
  end

  // blink phase counter
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      blink_q <= '0;
    else
      blink_q <= blink_d;
  end

  assign blank_h = blank && (state_q == SET_H);
  assign blank_m = blank && (state_q == SET_M);
  assign blank_s = blank && (state_q == SET_S);
`else
  assign blank_h = 1'b0;
  assign blank_m = 1'b0;
  assign blank_s = 1'b0;
`endif

  // registered digit drive
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      seg7h1 <= SEG_0;
      seg7h0 <= SEG_0;
      seg7m1 <= SEG_0;
      seg7m0 <= SEG_0;
      seg7s1 <= SEG_0;
      seg7s0 <= SEG_0;
    end else begin
      seg7h1 <= blank_h ? SEG_BLANK
                        : bcd_to_seg7(hh_q[7:4]);
      seg7h0 <= blank_h ? SEG_BLANK
                        : bcd_to_seg7(hh_q[3:0]);
      seg7m1 <= blank_m ? SEG_BLANK
                        : bcd_to_seg7(mm_q[7:4]);
      seg7m0 <= blank_m ? SEG_BLANK
                        : bcd_to_seg7(mm_q[3:0]);
      seg7s1 <= blank_s ? SEG_BLANK
                        : bcd_to_seg7(ss_q[7:4]);
      seg7s0 <= blank_s ? SEG_BLANK
                        : bcd_to_seg7(ss_q[3:0]);
    end
  end

  assign leds = {3'b000, hb_q, state_onehot(state_q)};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized bench for clock_set_ctrl against a
// seconds-of-day / event-queue reference model.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 20;
  localparam int DB     = 4;
  localparam int HALF   = CLK_HZ / 2;
  localparam int QUART  = CLK_HZ / 4;
`ifdef CLOCK_SET_CTRL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [6:0] PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       btsel_n = 1'b1;
  logic       btmode_n = 1'b1;
  logic       btinc_n = 1'b1;
  logic [6:0] seg7s0, seg7s1, seg7m0;
  logic [6:0] seg7m1, seg7h0, seg7h1;
  logic [7:0] leds;

  clock_set_ctrl #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .btsel_n    (btsel_n),
    .btmode_n   (btmode_n),
    .btinc_n    (btinc_n),
    .seg7s0     (seg7s0),
    .seg7s1     (seg7s1),
    .seg7m0     (seg7m0),
    .seg7m1     (seg7m1),
    .seg7h0     (seg7h0),
    .seg7h1     (seg7h1),
    .leds       (leds)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: st 0=RUN 1=H 2=M 3=S
  int m_st, m_h, m_m, m_s, m_run, m_hb, m_bl;
  int p_st, p_h, p_m, p_s, p_bl;
  int qm[$], qs[$], qi[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [13:0] pair(
    input int v, input bit blank
  );
    logic [6:0] hi, lo;
    hi = PAT[v / 10];
    lo = PAT[v % 10];
    if (blank) begin
      hi = 7'h7F;
      lo = 7'h7F;
    end
    return {hi, lo};
  endfunction

  function automatic logic [41:0] exp_seg();
    bit off;
    off = BLINK && ((p_bl % HALF) >= QUART);
    return {pair(p_h, off && p_st == 1),
            pair(p_m, off && p_st == 2),
            pair(p_s, off && p_st == 3)};
  endfunction

  task automatic step();
    bit em, es, ei;
    int t;
    @(posedge clk_clk);
    cyc++;
    p_st = m_st; p_h = m_h; p_m = m_m;
    p_s = m_s; p_bl = m_bl;
    em = 0; es = 0; ei = 0;
    if (reset_reset) begin
      m_st = 0; m_h = 0; m_m = 0; m_s = 0;
      m_run = 0; m_hb = 0; m_bl = 0;
      p_st = 0; p_h = 0; p_m = 0; p_s = 0; p_bl = 0;
      qm.delete(); qs.delete(); qi.delete();
    end else begin
      if (qm.size() > 0 && qm[0] == cyc) begin
        em = 1; void'(qm.pop_front());
      end
      if (qs.size() > 0 && qs[0] == cyc) begin
        es = 1; void'(qs.pop_front());
      end
      if (qi.size() > 0 && qi[0] == cyc) begin
        ei = 1; void'(qi.pop_front());
      end
      if (m_st == 0) begin
        if (em) begin
          m_st = 1; m_run = 0; m_bl = 0;
        end else begin
          m_run++;
          if (m_run == CLK_HZ) begin
            m_run = 0;
            m_hb = 1 - m_hb;
            t = m_h * 3600 + m_m * 60 + m_s + 1;
            if (t == 86400) t = 0;
            m_h = t / 3600;
            m_m = (t / 60) % 60;
            m_s = t % 60;
          end
        end
      end else if (em) begin
        m_st = 0; m_run = 0;
      end else if (es) begin
        m_st = (m_st == 3) ? 1 : m_st + 1;
        m_bl = 0;
      end else if (ei) begin
        if (m_st == 1) m_h = (m_h + 1) % 24;
        if (m_st == 2) m_m = (m_m + 1) % 60;
        if (m_st == 3) m_s = (m_s + 1) % 60;
        m_bl = 0;
      end else begin
        m_bl++;
      end
    end
    #1;
    chk("seg", {seg7h1, seg7h0, seg7m1,
                seg7m0, seg7s1, seg7s0}, exp_seg());
    chk("leds", leds, 64'((1 << m_st) + (m_hb << 4)));
  endtask

  task automatic press(input bit bm, input bit bs,
                       input bit bi, input int hold,
                       input int gap);
    int c;
    c = cyc;
    if (bm) begin btmode_n = 0; qm.push_back(c + DB + 4); end
    if (bs) begin btsel_n = 0; qs.push_back(c + DB + 4); end
    if (bi) begin btinc_n = 0; qi.push_back(c + DB + 4); end
    repeat (hold) step();
    btmode_n = 1; btsel_n = 1; btinc_n = 1;
    repeat (gap) step();
  endtask

  task automatic p1(input bit bm, input bit bs,
                    input bit bi);
    press(bm, bs, bi, DB + 2, DB + 4);
  endtask

  task automatic do_reset();
    reset_reset = 1;
    repeat (2) step();
    reset_reset = 0;
  endtask

  initial begin
    int c;
    logic [2:0] mask;
    do_reset();
    chk("rst_seg", {seg7h1, seg7h0, seg7m1,
                    seg7m0, seg7s1, seg7s0},
        {6{7'h40}});
    chk("rst_leds", leds, 8'h01);
    repeat (21) step();
    chk("ss01", seg7s0, 7'h79);
    chk("hb1", leds[4], 1'b1);
    repeat (40) step();
    chk("ss03", seg7s0, 7'h30);

    // bounce on mode, then settle low
    do_reset();
    for (int k = 0; k < 6; k++) begin
      btmode_n = ~btmode_n;
      repeat (2) step();
    end
    btmode_n = 0;
    c = cyc;
    qm.push_back(c + DB + 4);
    repeat (8) step();
    chk("bounce_state", leds[3:0], 4'h2);
    repeat (2) step();
    btmode_n = 1;
    repeat (DB + 4) step();
    p1(1, 0, 0);

    // set flow: minutes wrap past 59
    p1(1, 0, 0);
    p1(0, 1, 0);
    repeat (61) p1(0, 0, 1);
    p1(1, 0, 0);
    repeat (25) step();

    // priority: mode beats sel; inc ignored in RUN
    p1(1, 0, 0);
    p1(0, 1, 0);
    p1(1, 1, 0);
    p1(0, 0, 1);
    repeat (5) step();

    // rollover from 23:59:59
    p1(1, 0, 0);
    while (m_h != 23) p1(0, 0, 1);
    p1(0, 1, 0);
    while (m_m != 59) p1(0, 0, 1);
    p1(0, 1, 0);
    while (m_s != 59) p1(0, 0, 1);
    p1(1, 0, 0);
    repeat (30) step();

    // reset in SET while a button is mid-debounce
    p1(1, 0, 0);
    btsel_n = 0;
    repeat (3) step();
    reset_reset = 1;
    btsel_n = 1;
    step();
    reset_reset = 0;
    repeat (DB + 6) step();

    // random button traffic
    repeat (60) begin
      mask = 3'($urandom_range(1, 7));
      press(mask[2], mask[1], mask[0],
            DB + 2 + $urandom_range(0, 4),
            DB + 4 + $urandom_range(0, 40));
    end
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
